// File: rtl/branch_redirect_unit.sv
// Fetch PC sequencer: pc+4 stepping, branch redirects (deferred under stall), timed flush, EX flag latch.
// Redirects take effect on the first unstalled edge; flush stays high for FLUSH_CYCLES unstalled cycles.
module branch_redirect_unit #(
  parameter int                ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              alu_zero,
  input  logic              setFlags,
  input  logic              TakeBranch,
  input  logic [ADDR_W-1:0] br_target,
  output logic              negative,
  output logic              overflow,
  output logic              carry_out,
  output logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic              misalign
);

  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

  localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        flags_q, flags_d;
  logic              misalign_q, misalign_d;
  logic              flush_q, flush_d;

  logic [ADDR_W-1:0] aligned_target;
  logic [ADDR_W-1:0] pc_inc;

  assign aligned_target = {br_target[ADDR_W-1:2], 2'b00};
  assign pc_inc         = pc_q + ADDR_W'(4);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_target_d = pend_target_q;
    pc_d          = pc_q;
    flags_d       = flags_q;
    misalign_d    = misalign_q;

    case (state_q)
      RUN: begin
        if (TakeBranch) begin
          misalign_d = misalign_q | (|br_target[1:0]);
          if (stall) begin
            pend_target_d = aligned_target;
            state_d       = PEND;
          end else begin
            pc_d    = aligned_target;
            cnt_d   = FLUSH_CNT;
            state_d = FLUSH;
          end
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      // Younger branches are ignored here: the older pending one owns the redirect.
      PEND: begin
        if (!stall) begin
          pc_d    = pend_target_q;
          cnt_d   = FLUSH_CNT;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!stall) begin
          pc_d  = pc_inc;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase

    // Instructions in EX during a flush are being killed, so their flags are dropped.
    if (setFlags && !stall && state_q != FLUSH) begin
      flags_d = {alu_negative, alu_overflow, alu_carry_out, alu_zero};
    end

    flush_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      pend_target_q <= '0;
      pc_q          <= RESET_PC;
      flags_q       <= 4'd0;
      misalign_q    <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_target_q <= pend_target_d;
      pc_q          <= pc_d;
      flags_q       <= flags_d;
      misalign_q    <= misalign_d;
      flush_q       <= flush_d;
    end
  end

  assign {negative, overflow, carry_out, zero} = flags_q;
  assign pc       = pc_q;
  assign flush    = flush_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed scenarios plus randomized traffic checked against a queue/counter model of the redirect rules.
module tb_branch_redirect_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset, stall, setFlags, TakeBranch;
  logic        alu_negative, alu_overflow, alu_carry_out, alu_zero;
  logic [63:0] br_target;
  logic        negative, overflow, carry_out, zero;
  logic [63:0] pc;
  logic        flush, misalign;

  int errors = 0;
  int checks = 0;

  // Reference model: pending redirect as a queue, flush as remaining-cycle count.
  logic [63:0] m_pc;
  logic [3:0]  m_flags;
  logic        m_mis;
  int          m_fl;
  logic [63:0] m_pend[$];

  branch_redirect_unit #(.ADDR_W(64), .RESET_PC(64'h0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
    .setFlags(setFlags), .TakeBranch(TakeBranch), .br_target(br_target),
    .negative(negative), .overflow(overflow), .carry_out(carry_out), .zero(zero),
    .pc(pc), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic st, input logic tbr,
                      input logic [63:0] tgt, input logic sf, input logic [3:0] alu);
    reset = rst; stall = st; TakeBranch = tbr; br_target = tgt; setFlags = sf;
    {alu_negative, alu_overflow, alu_carry_out, alu_zero} = alu;
    @(posedge clk);
    if (rst) begin
      m_pc = 64'h0; m_flags = 4'h0; m_mis = 1'b0; m_fl = 0; m_pend.delete();
    end else begin
      if (sf && !st && m_fl == 0) m_flags = alu;
      if (m_fl > 0) begin
        if (!st) begin m_pc = m_pc + 64'd4; m_fl = m_fl - 1; end
      end else if (m_pend.size() > 0) begin
        if (!st) begin m_pc = m_pend.pop_front(); m_fl = FC; end
      end else if (tbr) begin
        if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        if (st) m_pend.push_back(tgt & ~64'h3);
        else begin m_pc = tgt & ~64'h3; m_fl = FC; end
      end else if (!st) begin
        m_pc = m_pc + 64'd4;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 4'h0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0013, 1'b1, 4'hF);
    checks++;
    if ({pc, flush, misalign, negative, overflow, carry_out, zero} !== {64'h0, 6'b0}) begin
      errors++;
      $display("FAIL reset_state actual pc=%h flush=%b mis=%b flags=%b%b%b%b required pc=0 all zero",
               pc, flush, misalign, negative, overflow, carry_out, zero);
    end
  endtask

  task automatic test_free_run();
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 4'h0);
    for (int i = 1; i <= 3; i++) begin
      idle();
      checks++;
      if (pc !== 64'(4 * i) || flush !== 1'b0) begin
        errors++;
        $display("FAIL free_run[%0d] actual pc=%h flush=%b required pc=%h flush=0", i, pc, flush, 64'(4 * i));
      end
    end
  endtask

  task automatic test_taken_branch();
    logic [63:0] exp_pc[3];
    logic        exp_fl[3];
    exp_pc = '{64'h40, 64'h44, 64'h48};
    exp_fl = '{1'b1, 1'b1, 1'b0};
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 4'h0);
    idle(); idle();
    checks++;
    if (pc !== 64'h8) begin errors++; $display("FAIL branch_setup actual pc=%h required pc=8", pc); end
    step(1'b0, 1'b0, 1'b1, 64'h40, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pc !== exp_pc[i] || flush !== exp_fl[i]) begin
        errors++;
        $display("FAIL taken_branch[%0d] actual pc=%h flush=%b required pc=%h flush=%b",
                 i, pc, flush, exp_pc[i], exp_fl[i]);
      end
      if (i < 2) idle();
    end
  endtask

  task automatic test_branch_under_stall();
    logic [63:0] held;
    held = pc;
    step(1'b0, 1'b1, 1'b1, 64'h100, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 64'h200, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 4'h0);
    checks++;
    if (pc !== held || flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold actual pc=%h flush=%b required pc=%h flush=0", pc, flush, held);
    end
    idle();
    checks++;
    if (pc !== 64'h100 || flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_redirect actual pc=%h flush=%b required pc=100 flush=1", pc, flush);
    end
    idle();
    checks++;
    if (pc !== 64'h104 || flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_flush2 actual pc=%h flush=%b required pc=104 flush=1", pc, flush);
    end
    idle();
    checks++;
    if (pc !== 64'h108 || flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_done actual pc=%h flush=%b required pc=108 flush=0", pc, flush);
    end
  endtask

  task automatic test_flags();
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 4'b1001);
    checks++;
    if (zero !== 1'b1 || negative !== 1'b1 || overflow !== 1'b0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL flags_latch actual nvcz=%b%b%b%b required 1001", negative, overflow, carry_out, zero);
    end
    step(1'b0, 1'b0, 1'b1, 64'h80, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 4'b0110);
    checks++;
    if ({negative, overflow, carry_out, zero} !== 4'b1001) begin
      errors++;
      $display("FAIL flags_in_flush actual nvcz=%b%b%b%b required 1001", negative, overflow, carry_out, zero);
    end
  endtask

  task automatic test_misalign_wrap();
    idle(); idle();
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'h0);
    checks++;
    if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_target actual pc=%h mis=%b required pc=fffffffffffffffc mis=1", pc, misalign);
    end
    idle();
    checks++;
    if (pc !== 64'h0) begin errors++; $display("FAIL pc_wrap actual pc=%h required pc=0", pc); end
  endtask

  task automatic test_reset_mid_flush();
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 4'h0);
    idle();
    step(1'b0, 1'b0, 1'b1, 64'h41, 1'b0, 4'h0);
    checks++;
    if (flush !== 1'b1 || misalign !== 1'b1 || pc !== 64'h40) begin
      errors++;
      $display("FAIL rmf_setup actual pc=%h flush=%b mis=%b required pc=40 flush=1 mis=1", pc, flush, misalign);
    end
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 4'h0);
    checks++;
    if (pc !== 64'h0 || flush !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL rmf_reset actual pc=%h flush=%b mis=%b required pc=0 flush=0 mis=0", pc, flush, misalign);
    end
    idle();
    checks++;
    if (pc !== 64'h4 || flush !== 1'b0) begin
      errors++;
      $display("FAIL rmf_run actual pc=%h flush=%b required pc=4 flush=0", pc, flush);
    end
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 4'h0);
    for (int i = 0; i < 3000; i++) begin
      tgt = {$urandom(), $urandom()};
      if ($urandom_range(3) == 0) tgt = m_pc;
      step($urandom_range(79) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
           tgt, $urandom_range(1) == 1, 4'($urandom_range(15)));
      checks++;
      if ({pc, flush, misalign, negative, overflow, carry_out, zero} !==
          {m_pc, m_fl > 0, m_mis, m_flags}) begin
        errors++;
        $display("FAIL random[%0d] actual pc=%h fl=%b mis=%b f=%b%b%b%b required pc=%h fl=%b mis=%b f=%b",
                 i, pc, flush, misalign, negative, overflow, carry_out, zero,
                 m_pc, m_fl > 0, m_mis, m_flags);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; TakeBranch = 1'b0; br_target = 64'h0; setFlags = 1'b0;
    {alu_negative, alu_overflow, alu_carry_out, alu_zero} = 4'h0;
    m_pc = 64'h0; m_flags = 4'h0; m_mis = 1'b0; m_fl = 0;
    test_reset();
    test_free_run();
    test_taken_branch();
    test_branch_under_stall();
    test_flags();
    test_misalign_wrap();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
